// File: rtl/ahfp_acc.sv
// IEEE-754 single-precision accumulator with a 5-state ALIGN/ADD/NORM pipeline FSM.
// Optional build macro AHFP_ACC_COUNT_EN adds a 16-bit completed-ACC counter.
module ahfp_acc (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [1:0]  n,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic        done,
  output logic [31:0] result
);

  localparam int unsigned MW = 23;
  localparam int unsigned EW = 8;
  localparam int unsigned DW = 32;

  localparam logic [1:0] CMD_ACC   = 2'd0;
  localparam logic [1:0] CMD_CLEAR = 2'd1;
  localparam logic [1:0] CMD_COUNT = 2'd3;

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        cmd_q, cmd_d;
  logic [DW-1:0]     opb_q, opb_d;
  logic [DW-1:0]     s_q, s_d;
  logic [MW+1:0]     mb_q, mb_d;
  logic [MW:0]       ms_q, ms_d;
  logic [EW-1:0]     exp_q, exp_d;
  logic              sign_q, sign_d;
  logic              sub_q, sub_d;
  logic              inf_q, inf_d;
  logic              done_q, done_d;
  logic [DW-1:0]     result_q, result_d;
`ifdef AHFP_ACC_COUNT_EN
  logic [15:0]       count_q, count_d;
`endif

  logic [EW-1:0]     ea, eb, big_e, sml_e, diff;
  logic [30:0]       mag_a, mag_b;
  logic              b_big, big_sign;
  logic [MW-1:0]     big_frac, sml_frac, nman;
  logic [MW:0]       big_m, sml_m, sml_sh;
  logic [MW+1:0]     sum;
  logic [4:0]        lz;
  logic signed [9:0] nexp;
  logic [DW-1:0]     new_s, count_res;

  logic unused_datab;
  assign unused_datab = ^datab;

  function automatic logic [4:0] lzc24(input logic [23:0] v);
    logic [4:0] cnt;
    logic       hit;
    cnt = '0;
    hit = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      if (!hit) begin
        if (v[i]) hit = 1'b1;
        else      cnt = cnt + 5'd1;
      end
    end
    return cnt;
  endfunction

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    opb_d    = opb_q;
    s_d      = s_q;
    mb_d     = mb_q;
    ms_d     = ms_q;
    exp_d    = exp_q;
    sign_d   = sign_q;
    sub_d    = sub_q;
    inf_d    = inf_q;
    done_d   = 1'b0;
    result_d = '0;
`ifdef AHFP_ACC_COUNT_EN
    count_d   = count_q;
    count_res = {16'd0, count_q};
`else
    count_res = '0;
`endif

    // Alignment: a zero exponent field means zero magnitude.
    ea       = s_q[30:23];
    eb       = opb_q[30:23];
    mag_a    = (ea == '0) ? '0 : s_q[30:0];
    mag_b    = (eb == '0) ? '0 : opb_q[30:0];
    b_big    = mag_b > mag_a;
    big_e    = b_big ? eb : ea;
    sml_e    = b_big ? ea : eb;
    big_sign = b_big ? opb_q[31] : s_q[31];
    big_frac = b_big ? opb_q[22:0] : s_q[22:0];
    sml_frac = b_big ? s_q[22:0] : opb_q[22:0];
    big_m    = (big_e == '0) ? '0 : {1'b1, big_frac};
    sml_m    = (sml_e == '0) ? '0 : {1'b1, sml_frac};
    diff     = big_e - sml_e;
    sml_sh   = (diff >= 8'd26) ? '0 : (sml_m >> diff);

    sum = sub_q ? (mb_q - {1'b0, ms_q}) : (mb_q + {1'b0, ms_q});

    // Normalisation: carry shifts right by one, otherwise left by the leading-zero count.
    lz = lzc24(mb_q[23:0]);
    if (mb_q[24]) begin
      nman = mb_q[23:1];
      nexp = 10'({2'b00, exp_q}) + 10'd1;
    end else begin
      nman = mb_q[22:0] << lz;
      nexp = 10'({2'b00, exp_q}) - 10'(lz);
    end
    if (inf_q)                  new_s = {sign_q, 8'hFF, 23'd0};
    else if (mb_q == '0)        new_s = '0;
    else if (nexp >= 10'sd255)  new_s = {sign_q, 8'hFF, 23'd0};
    else if (nexp <= 10'sd0)    new_s = '0;
    else                        new_s = {sign_q, nexp[7:0], nman};

    case (state_q)
      IDLE: begin
        if (start) begin
          cmd_d = n;
          if (n == CMD_ACC) begin
            opb_d   = dataa;
            state_d = ALIGN;
          end else begin
            state_d  = DONE;
            done_d   = 1'b1;
            result_d = (n == CMD_COUNT) ? count_res : s_q;
          end
        end
      end
      ALIGN: begin
        mb_d   = {1'b0, big_m};
        ms_d   = sml_sh;
        exp_d  = big_e;
        sign_d = big_sign;
        sub_d  = s_q[31] ^ opb_q[31];
        inf_d  = 1'b0;
        // The new operand's infinity takes precedence over an infinite sum.
        if (eb == 8'hFF) begin
          inf_d  = 1'b1;
          sign_d = opb_q[31];
        end else if (ea == 8'hFF) begin
          inf_d  = 1'b1;
          sign_d = s_q[31];
        end
        state_d = ADD;
      end
      ADD: begin
        mb_d    = sum;
        state_d = NORM;
      end
      NORM: begin
        s_d      = new_s;
        done_d   = 1'b1;
        result_d = new_s;
`ifdef AHFP_ACC_COUNT_EN
        count_d  = count_q + 16'd1;
`endif
        state_d  = DONE;
      end
      DONE: begin
        if (cmd_q == CMD_CLEAR) begin
          s_d     = '0;
`ifdef AHFP_ACC_COUNT_EN
          count_d = '0;
`endif
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cmd_q    <= '0;
      opb_q    <= '0;
      s_q      <= '0;
      mb_q     <= '0;
      ms_q     <= '0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      sub_q    <= 1'b0;
      inf_q    <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
`ifdef AHFP_ACC_COUNT_EN
      count_q  <= '0;
`endif
    end else if (clk_en) begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      opb_q    <= opb_d;
      s_q      <= s_d;
      mb_q     <= mb_d;
      ms_q     <= ms_d;
      exp_q    <= exp_d;
      sign_q   <= sign_d;
      sub_q    <= sub_d;
      inf_q    <= inf_d;
      done_q   <= done_d;
      result_q <= result_d;
`ifdef AHFP_ACC_COUNT_EN
      count_q  <= count_d;
`endif
    end
  end

  assign done   = done_q;
  assign result = result_q;

endmodule

// File: doc/ahfp_acc.md
AHFP_ACC -- requirements
Module: ahfp_acc

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port clk_en, input, 1; when low, all state, including the FSM, holds.
REQ-004 SHALL have port start, input, 1, one-cycle command strobe; sampled only in IDLE.
REQ-005 SHALL have port n, input, 2, command: 0 ACC, 1 CLEAR, 2 READ, 3 COUNT.
REQ-006 SHALL have port dataa, input, 32, IEEE-754 single operand (product from ahfp_mult); used by ACC only.
REQ-007 SHALL have port datab, input, 32, unused; reserved.
REQ-008 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-009 SHALL have port result, output, 32; valid only while done=1, 0 otherwise.

Function
REQ-010 SHALL hold a 32-bit sum register, s, in IEEE single format.
REQ-011 SHALL implement FSM states IDLE, ALIGN, ADD, NORM, DONE.
REQ-012 ACC: IDLE -> ALIGN -> ADD -> NORM -> DONE -> IDLE; done SHALL be high exactly 4 cycles after the start cycle; result = new s.
REQ-013 CLEAR/READ/COUNT: IDLE -> DONE -> IDLE; done SHALL be high 1 cycle after start.
REQ-014 CLEAR SHALL return the old s and set s = 0x00000000.
REQ-015 READ SHALL return s unchanged.
REQ-016 start while not in IDLE SHALL be ignored, with no queuing.
REQ-017 ALIGN: the smaller-magnitude operand SHALL be shifted right by the exponent difference, with bits shifted out truncated; a difference >= 26 SHALL yield an aligned value of 0.
REQ-018 ADD: same signs add magnitudes; otherwise subtract smaller from larger; result sign = sign of larger; 25-bit datapath keeps the carry.
REQ-019 NORM: a single-cycle leading-zero count SHALL renormalise; a carry-out SHALL shift right 1 and increment the exponent; the mantissa SHALL truncate to 23 bits.
REQ-020 Exponent field 0 (either operand) SHALL be treated as zero magnitude; denormals are not supported.
REQ-021 An exact-zero sum SHALL be stored as +0 (0x00000000).
REQ-022 A post-NORM exponent >= 255 SHALL saturate s to signed infinity (exp 255, mantissa 0).
REQ-023 A post-NORM exponent <= 0 SHALL flush s to +0.
REQ-024 Operands with exponent 255 SHALL be treated as infinity: s becomes that infinity; NaN payloads are not preserved.
REQ-025 s SHALL only be written in NORM (ACC) or DONE (CLEAR).

Reset
REQ-026 reset SHALL force, asynchronously, FSM=IDLE, s=0, done=0, result=0, and all pipeline registers = 0.
REQ-027 reset during any ACC state SHALL abort it; no done pulse and no write to s.
REQ-028 The first start SHALL be accepted in the first clk_en cycle after reset deasserts.

Configuration
REQ-029 With macro AHFP_ACC_COUNT_EN defined, a 16-bit counter SHALL increment on each completed ACC, wrap 0xFFFF -> 0, and clear on CLEAR/reset; COUNT returns {16'd0, count}.
REQ-030 Without AHFP_ACC_COUNT_EN, no counter is built; COUNT SHALL return 0x00000000 with 1-cycle done.

Verification
REQ-031 reset; ACC 0x3F800000, ACC 0x40000000, READ -> result 0x40400000; each ACC done exactly 4 cycles after start.
REQ-032 ACC 0x40400000, ACC 0xC0400000, READ -> 0x00000000; then ACC 0xBF800000, READ -> 0xBF800000.
REQ-033 CLEAR on s=0x4B800000 -> result 0x4B800000; then READ -> 0x00000000; ACC 0x4B800000 then 0x3F800000 -> 0x4B800000 (truncation).
REQ-034 ACC 0x7F7FFFFF twice -> 0x7F800000; start pulsed in ALIGN -> ignored, single done.
REQ-035 Assert reset in ADD state after s=0x3F800000 -> no done, READ -> 0x00000000; clk_en low 3 cycles mid-ACC -> done delayed 3 cycles.
REQ-036 AHFP_ACC_COUNT_EN: 3 ACCs then COUNT -> 0x00000003, CLEAR then COUNT -> 0; undefined: COUNT -> 0x00000000.
